// File: rtl/fetch.sv
// Instruction-fetch stage: holds the fetch PC, issues one memory request at a time,
// and presents fetched words to decode with stall back-pressure and redirect squash.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] next_instruction,
  output logic [31:0] PC,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        kill;
  logic [31:0] target;

  // Redirect targets are forced word-aligned.
  assign target   = branch_target & ~32'h0000_0003;
  assign mem_addr = fetch_pc;
  assign mem_req  = (state == S_REQ) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_REQ;
      fetch_pc         <= RESET_PC;
      req_pc           <= RESET_PC;
      PC               <= RESET_PC;
      kill             <= 1'b0;
      instr_valid      <= 1'b0;
      next_instruction <= NOP;
    end else if (PCSrc) begin
      // Redirect wins over every other event; any in-flight old-path word is killed.
      fetch_pc         <= target;
      instr_valid      <= 1'b0;
      next_instruction <= NOP;
      case (state)
        S_REQ: begin
          if (mem_ready) begin
            req_pc <= fetch_pc;
            kill   <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            kill  <= 1'b0;
            state <= S_REQ;
          end else begin
            kill <= 1'b1;
          end
        end
        S_VALID: state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (mem_ready) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              next_instruction <= mem_rdata;
              PC               <= req_pc;
              instr_valid      <= 1'b1;
              state            <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (!stall) begin
            instr_valid      <= 1'b0;
            next_instruction <= NOP;
            state            <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: expected request addresses and presented
// instructions are queued by the stimulus and checked by a monitor.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] next_instruction;
  logic [31:0] PC;
  logic        instr_valid;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic [31:0] req_q[$];
  exp_t        ins_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        prev_valid = 1'b0;

  fetch #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc),
    .branch_target(branch_target), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .next_instruction(next_instruction), .PC(PC), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are held across exactly one rising edge; returns just after the following falling edge.
  task automatic cyc(input logic r_rdy = 1'b0, input logic r_rv = 1'b0,
                     input logic [31:0] r_rd = '0, input logic r_st = 1'b0,
                     input logic r_pcs = 1'b0, input logic [31:0] r_bt = '0,
                     input logic r_rst = 1'b0);
    mem_ready     = r_rdy;
    mem_rvalid    = r_rv;
    mem_rdata     = r_rd;
    stall         = r_st;
    PCSrc         = r_pcs;
    branch_target = r_bt;
    rst           = r_rst;
    @(negedge clk);
    #1;
  endtask

  task automatic exp_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic exp_ins(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc  = p;
    e.ins = i;
    ins_q.push_back(e);
  endtask

  // Monitor samples late in the low phase, after inputs settle and before the rising edge.
  initial begin
    logic [31:0] ea;
    exp_t        ei;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        if (mem_req && mem_ready) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr %h expected no request", mem_addr);
          end else begin
            ea = req_q.pop_front();
            check("req_addr", mem_addr, ea);
          end
        end
        if (instr_valid && !prev_valid) begin
          if (ins_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL instr_unexpected: got PC %h instr %h expected none", PC, next_instruction);
          end else begin
            ei = ins_q.pop_front();
            check("instr_pc", PC, ei.pc);
            check("instr_word", next_instruction, ei.ins);
          end
        end
        if (!instr_valid) check("bubble_nop", next_instruction, NOP);
        prev_valid = instr_valid;
      end
    end
  end

  initial begin
    @(negedge clk);
    #1;
    // Reset
    cyc(0, 0, '0, 0, 0, '0, 1);
    cyc(0, 0, '0, 0, 0, '0, 1);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", next_instruction, NOP);
    check("rst_pc", PC, 32'h0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    mon_en = 1'b1;

    // Plain run: addresses 0 and 4
    cyc();
    check("run_mem_req", {31'd0, mem_req}, 32'd1);
    exp_req(32'h0);
    cyc(1);
    exp_ins(32'h0, 32'h0050_0093);
    cyc(0, 1, 32'h0050_0093);
    cyc();
    exp_req(32'h4);
    cyc(1);
    exp_ins(32'h4, 32'h0010_0113);
    cyc(0, 1, 32'h0010_0113);

    // Stall hold while presenting PC=4
    check("hold0_valid", {31'd0, instr_valid}, 32'd1);
    for (int unsigned k = 0; k < 4; k++) begin
      cyc(0, 0, '0, 1);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_pc", PC, 32'h4);
      check("hold_instr", next_instruction, 32'h0010_0113);
      check("hold_no_req", {31'd0, mem_req}, 32'd0);
    end
    cyc();
    check("after_hold_addr", mem_addr, 32'h8);
    check("after_hold_req", {31'd0, mem_req}, 32'd1);

    // Redirect while waiting for address 8
    exp_req(32'h8);
    cyc(1);
    cyc();
    cyc(0, 0, '0, 0, 1, 32'h0000_0103);
    cyc(0, 1, 32'hDEAD_BEEF);
    check("kill_wait_valid", {31'd0, instr_valid}, 32'd0);
    check("kill_wait_addr", mem_addr, 32'h100);
    exp_req(32'h100);
    cyc(1);
    exp_ins(32'h100, 32'h1111_1111);
    cyc(0, 1, 32'h1111_1111);
    cyc();

    // Redirect coinciding with request acceptance
    exp_req(32'h104);
    cyc(1, 0, '0, 0, 1, 32'h0000_0200);
    cyc(0, 1, 32'hBAD0_0001);
    check("kill_acc_valid", {31'd0, instr_valid}, 32'd0);
    check("kill_acc_addr", mem_addr, 32'h200);
    exp_req(32'h200);
    cyc(1);
    exp_ins(32'h200, 32'h2222_2222);
    cyc(0, 1, 32'h2222_2222);
    cyc();

    // Redirect coinciding with the response
    exp_req(32'h204);
    cyc(1);
    cyc(0, 1, 32'hBAD0_0002, 0, 1, 32'h0000_0300);
    check("kill_rv_valid", {31'd0, instr_valid}, 32'd0);
    check("kill_rv_addr", mem_addr, 32'h300);
    exp_req(32'h300);
    cyc(1);
    exp_ins(32'h300, 32'h3333_3333);
    cyc(0, 1, 32'h3333_3333);

    // Redirect squashes a stalled presentation; PC keeps its last value
    cyc(0, 0, '0, 1, 1, 32'hFFFF_FFFE);
    check("squash_valid", {31'd0, instr_valid}, 32'd0);
    check("squash_pc", PC, 32'h300);
    check("squash_addr", mem_addr, 32'hFFFF_FFFC);

    // Wrap from FFFF_FFFC to 0
    exp_req(32'hFFFF_FFFC);
    cyc(1);
    exp_ins(32'hFFFF_FFFC, 32'h4444_4444);
    cyc(0, 1, 32'h4444_4444);
    cyc();
    check("wrap_addr", mem_addr, 32'h0);

    // Reset in the middle of a transaction
    exp_req(32'h0);
    cyc(1);
    check("pre_rst_addr", mem_addr, 32'h4);
    cyc(0, 0, '0, 0, 0, '0, 1);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_pc", PC, 32'h0);
    check("mid_rst_instr", next_instruction, NOP);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    cyc(0, 1, 32'hBAD0_0003);
    check("late_rv_valid", {31'd0, instr_valid}, 32'd0);
    check("post_rst_req", {31'd0, mem_req}, 32'd1);
    exp_req(32'h0);
    cyc(1);
    exp_ins(32'h0, 32'h5555_5555);
    cyc(0, 1, 32'h5555_5555);
    cyc();
    cyc();
    cyc();

    checks++;
    if (req_q.size() != 0) begin
      errors++;
      $display("FAIL req_drain: got %0d pending expected 0", req_q.size());
    end
    checks++;
    if (ins_q.size() != 0) begin
      errors++;
      $display("FAIL instr_drain: got %0d pending expected 0", ins_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
